// File: rtl/wide_add_pkg.sv
// Shared types and constants for the sequential wide-operand adder.
package wide_add_pkg;

    localparam int SLICE_W = 32;

    typedef enum logic [1:0] {
        WA_IDLE,
        WA_RUN,
        WA_DONE
    } wa_state_t;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/fulladder32.sv
// 32-bit ripple-carry slice adder with carry in and carry out.
module fulladder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 32; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[32];
    end

endmodule

// File: rtl/wide_add_seq.sv
// WORDS x 32-bit add/subtract built from one 32-bit slice adder, one slice per
// cycle LSB first, with the carry chained through a register between slices.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [SLICE_W*WORDS-1:0] a_i,
    input  logic [SLICE_W*WORDS-1:0] b_i,
    input  logic                     sub_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [SLICE_W*WORDS-1:0] sum_o,
    output logic                     carry_o,
    output logic                     zero_o
);

    localparam int            IW   = idx_width(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    wa_state_t state_q, state_d;

    logic [WORDS-1:0][SLICE_W-1:0] a_q, b_q, sum_q;
    logic [IW-1:0]                 idx_q;
    logic                          carry_q;
    logic                          carry_out_q;

    logic [SLICE_W-1:0] slice_sum;
    logic               slice_carry;

    fulladder32 u_slice (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_carry)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= WA_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WA_IDLE: if (valid_i) state_d = WA_RUN;
            WA_RUN:  if (idx_q == LAST) state_d = WA_DONE;
            WA_DONE: if (ready_i) state_d = WA_IDLE;
            default: state_d = WA_IDLE;
        endcase
    end

    // B is stored pre-inverted for subtraction; the +1 enters as slice 0 carry-in.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
        end else if (state_q == WA_IDLE && valid_i) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            idx_q   <= '0;
            carry_q <= sub_i;
        end else if (state_q == WA_RUN) begin
            sum_q[idx_q] <= slice_sum;
            carry_q      <= slice_carry;
            idx_q        <= idx_q + 1'b1;
            if (idx_q == LAST) begin
                carry_out_q <= slice_carry;
            end
        end
    end

    assign ready_o = (state_q == WA_IDLE);
    assign valid_o = (state_q == WA_DONE);
    assign sum_o   = sum_q;
    assign carry_o = carry_out_q;
    assign zero_o  = (sum_q == '0);

endmodule

// File: tb/tb_wide_add_seq.sv
// Bench for wide_add_seq: directed table at WORDS=4 plus randomized traffic
// into WORDS=4 and WORDS=2 instances checked against an arithmetic model.
module tb_wide_add_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         valid4 = 1'b0, valid2 = 1'b0, sub = 1'b0;
    logic [127:0] a = '0, b = '0;
    logic         ready4_i = 1'b0, ready2_i = 1'b0;

    logic         rdy4, vld4, c4, z4;
    logic [127:0] s4;
    logic         rdy2, vld2, c2, z2;
    logic [63:0]  s2;

    wide_add_seq #(.WORDS(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid4), .ready_o(rdy4),
        .a_i(a), .b_i(b), .sub_i(sub), .valid_o(vld4), .ready_i(ready4_i),
        .sum_o(s4), .carry_o(c4), .zero_o(z4)
    );

    wide_add_seq #(.WORDS(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid2), .ready_o(rdy2),
        .a_i(a[63:0]), .b_i(b[63:0]), .sub_i(sub), .valid_o(vld2), .ready_i(ready2_i),
        .sum_o(s2), .carry_o(c2), .zero_o(z2)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: result = A +/- B modulo 2^W; carry = overflow or (A >= B) when subtracting.
    function automatic logic [128:0] ref128(input logic [127:0] x, input logic [127:0] y, input logic s);
        if (s) return {(x >= y), x - y};
        return {1'b0, x} + {1'b0, y};
    endfunction

    function automatic logic [64:0] ref64(input logic [63:0] x, input logic [63:0] y, input logic s);
        if (s) return {(x >= y), x - y};
        return {1'b0, x} + {1'b0, y};
    endfunction

    typedef struct {
        logic [127:0] va;
        logic [127:0] vb;
        logic         vs;
        logic [127:0] es;
        logic         ec;
        logic         ez;
    } vec_t;

    vec_t tbl[7];

    task automatic run4(input string nm, input logic [127:0] ta, input logic [127:0] tb,
                        input logic ts, input logic [127:0] es, input logic ec, input logic ez);
        int lat;
        chk({nm, "_ready"}, rdy4, 1);
        a = ta; b = tb; sub = ts; valid4 = 1'b1;
        @(negedge clk);
        valid4 = 1'b0;
        lat = 0;
        while (!vld4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, lat, 4);
        chk({nm, "_sum"}, s4, es);
        chk({nm, "_carry"}, c4, ec);
        chk({nm, "_zero"}, z4, ez);
        ready4_i = 1'b1;
        @(negedge clk);
        ready4_i = 1'b0;
        chk({nm, "_valid_drop"}, vld4, 0);
    endtask

    initial begin
        logic [127:0] ones;
        logic [128:0] e4;
        logic [64:0]  e2;
        logic [127:0] bp_sum;
        logic         done4, done2;
        int           lat;

        ones = '1;
        tbl[0] = '{ones, 128'd1, 1'b0, 128'd0, 1'b1, 1'b1};
        tbl[1] = '{128'hFFFF_FFFF, 128'd1, 1'b0, 128'h1_0000_0000, 1'b0, 1'b0};
        tbl[2] = '{128'd5, 128'd7, 1'b1, ones - 128'd1, 1'b0, 1'b0};
        tbl[3] = '{128'd7, 128'd5, 1'b1, 128'd2, 1'b1, 1'b0};
        tbl[4] = '{128'd0, 128'd0, 1'b0, 128'd0, 1'b0, 1'b1};
        tbl[5] = '{128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
                   1'b1, 128'd0, 1'b1, 1'b1};
        tbl[6] = '{ones, ones, 1'b0, ones - 128'd1, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_ready", rdy4, 1);
        chk("rst_valid", vld4, 0);
        chk("rst_sum", s4, 0);
        chk("rst_carry", c4, 0);
        chk("rst_zero", z4, 1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) begin
            run4($sformatf("tbl%0d", i), tbl[i].va, tbl[i].vb, tbl[i].vs, tbl[i].es, tbl[i].ec, tbl[i].ez);
        end

        // Back-pressure: results stay frozen and a new request is ignored while DONE.
        a = 128'h0000_0001_0000_0002_0000_0003_0000_0004;
        b = 128'h0000_0010_0000_0020_0000_0030_0000_0040;
        sub = 1'b0; valid4 = 1'b1;
        bp_sum = 128'h0000_0011_0000_0022_0000_0033_0000_0044;
        @(negedge clk);
        valid4 = 1'b0;
        lat = 0;
        while (!vld4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_latency", lat, 4);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                a = ones; b = ones; sub = 1'b1; valid4 = 1'b1;
            end else begin
                valid4 = 1'b0;
            end
            chk("bp_valid", vld4, 1);
            chk("bp_sum", s4, bp_sum);
            chk("bp_carry", c4, 0);
            chk("bp_ready", rdy4, 0);
            @(negedge clk);
        end
        valid4 = 1'b0;
        chk("bp_still_valid", vld4, 1);
        ready4_i = 1'b1;
        @(negedge clk);
        ready4_i = 1'b0;
        chk("bp_release_valid", vld4, 0);
        chk("bp_release_ready", rdy4, 1);
        @(negedge clk);
        chk("bp_not_accepted", rdy4, 1);

        // Reset after two slices of a run discards the partial result.
        a = 128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DDDD_DDDD;
        b = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
        sub = 1'b0; valid4 = 1'b1;
        @(negedge clk);
        valid4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", rdy4, 1);
        chk("abort_valid", vld4, 0);
        chk("abort_sum", s4, 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_valid", vld4, 0);
        end
        run4("after_abort", 128'd3, 128'd4, 1'b0, 128'd7, 1'b0, 1'b0);

        // Random traffic into both widths with random result stalls.
        for (int n = 0; n < 2000; n++) begin
            chk("rand_ready4", rdy4, 1);
            chk("rand_ready2", rdy2, 1);
            a = {$urandom, $urandom, $urandom, $urandom};
            b = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom, $urandom, $urandom};
            sub = $urandom_range(0, 1) == 1;
            e4 = ref128(a, b, sub);
            e2 = ref64(a[63:0], b[63:0], sub);
            valid4 = 1'b1; valid2 = 1'b1;
            done4 = 1'b0; done2 = 1'b0;
            for (int cyc = 0; cyc < 64 && !(done4 && done2); cyc++) begin
                @(negedge clk);
                valid4 = 1'b0; valid2 = 1'b0;
                if (ready4_i) begin
                    ready4_i = 1'b0;
                    done4 = 1'b1;
                    chk("rand4_dup", vld4, 0);
                end else if (vld4 && !done4) begin
                    chk("rand4_sum", s4, e4[127:0]);
                    chk("rand4_carry", c4, e4[128]);
                    chk("rand4_zero", z4, e4[127:0] == '0);
                    ready4_i = $urandom_range(0, 2) == 0;
                end
                if (ready2_i) begin
                    ready2_i = 1'b0;
                    done2 = 1'b1;
                    chk("rand2_dup", vld2, 0);
                end else if (vld2 && !done2) begin
                    chk("rand2_sum", s2, e2[63:0]);
                    chk("rand2_carry", c2, e2[64]);
                    chk("rand2_zero", z2, e2[63:0] == '0);
                    ready2_i = $urandom_range(0, 2) == 0;
                end
            end
            if (!(done4 && done2)) begin
                chk("rand_timeout", {done4, done2}, 2'b11);
                ready4_i = 1'b0; ready2_i = 1'b0;
                break;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/wide_add_seq.md
# wide_add_seq

Multi-cycle wide-operand adder/subtractor that sits directly upstream of the 32-bit ripple slice adder `fulladder32`. It accepts WORDS×32-bit operands through a valid/ready handshake and feeds one 32-bit slice per cycle into a single `fulladder32` instance, least-significant slice first. It registers the slice sum and chains the carry between cycles, then presents the full-width result on a valid/ready output port. It is used wherever operands wider than 32 bits must be added without replicating the slice adder.

## Interface
- `WORDS`, default 4: number of 32-bit slices; operand width W = 32*WORDS; legal range 2..16.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `valid_i`  in  1  operand request valid.
- `ready_o`  out  1  block can accept a request.
- `a_i`  in  W  operand A.
- `b_i`  in  W  operand B.
- `sub_i`  in  1  0: A+B; 1: A−B.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  consumer accepts result.
- `sum_o`  out  W  result, modulo 2^W.
- `carry_o`  out  1  final carry out; when subtracting, 1 means no borrow (A ≥ B unsigned).
- `zero_o`  out  1  sum_o == 0.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**:
  - ready_o=1.
  - On valid_i&&ready_o: latch a_i, latch b_i (bitwise inverted if sub_i), and latch sub_i.
  - Set slice index idx=0 and carry register = sub_i.
  - Go to RUN.
- **RUN**:
  - ready_o=0.
  - Drive the slice adder with A[idx], B'[idx] and the carry register.
  - At the clock edge, write the slice sum into sum_o[32*idx +: 32] and store the slice carry_o into the carry register.
  - Increment idx.
  - On idx==WORDS−1: go to DONE and copy the slice carry to carry_o.
- **DONE**:
  - valid_o=1.
  - sum_o, carry_o and zero_o are held stable.
  - On ready_i: go to IDLE. valid_o=0 in the next cycle.
- valid_i is ignored outside IDLE. There is no queueing, and a dropped request is the requester's responsibility.
- Arithmetic:
  - Subtraction is A + ~B + 1, with the +1 injected as the carry into slice 0.
  - Slice carries propagate strictly through the carry register, never combinationally across slices.
- zero_o is computed from the registered sum_o. It is only meaningful while valid_o=1.
- Reset mid-operation: any state returns to IDLE on the next edge. The partial result is discarded and no valid_o is issued.

## Timing
- Reset values: ready_o=1, valid_o=0, sum_o=0, carry_o=0, zero_o=1 (consistent with sum_o=0); state=IDLE, idx=0, carry register=0.
- Accept edge T0: state=RUN from T0.
- Slice k is written at edge T0+k+1.
- valid_o rises at edge T0+WORDS, i.e. latency = WORDS cycles from the accept edge.
- Minimum request-to-request spacing is WORDS+2 cycles (the DONE cycle plus the IDLE re-accept cycle). Back-to-back acceptance from DONE is not supported.
- Back-pressure: valid_o stays high and the outputs are frozen for as long as ready_i=0. There is no timeout.
- ready_o is a pure decode of state (state==IDLE). It has no combinational path from valid_i.
- The slice-adder path is combinational within one cycle: 32-bit ripple plus operand mux. Synthesis must close this path at the target clock.

## Structure
- Package `wide_add_pkg`:
  - `SLICE_W = 32`.
  - State enum `wa_state_t {WA_IDLE, WA_RUN, WA_DONE}`.
  - Function for the slice index width, $clog2(WORDS).
- One sub-module: a single instance of the existing `fulladder32`, driven through idx-selected part-selects. No new arithmetic sub-modules.
- Datapath registers: A, B', sum_o, carry register, idx, state.

## Test plan
- WORDS=4, A=2^128−1, B=1, sub=0 → sum_o=0, carry_o=1, zero_o=1; valid_o exactly 4 cycles after the accept edge.
- A=0x0000…0000_FFFFFFFF, B=1, sub=0 → sum_o=0x0000…0001_00000000, carry_o=0, zero_o=0. This checks the inter-slice carry.
- A=5, B=7, sub=1 → sum_o=2^128−2 (0xFFFF…FFFE), carry_o=0 (borrow). Then A=7, B=5 → sum_o=2, carry_o=1.
- Hold ready_i=0 for 3 cycles after valid_o rises. Pulse valid_i with new operands meanwhile → valid_o, sum_o and carry_o unchanged; ready_o=0; the new request is not accepted; the result completes when ready_i=1.
- Deassert rst_ni for one cycle after 2 slices of a RUN → the next cycle shows state IDLE, valid_o=0, ready_o=1 and sum_o=0. Then a new request A=3, B=4 gives sum_o=7 with no corruption from the aborted operation.
- Random 2000 requests at WORDS=2 and WORDS=4, with random sub_i and random ready_i stalls → every result equals the reference model (A±B mod 2^W, carry/borrow); no result is lost or duplicated.
